// File: rtl/ram_fifo_ctrl_if.sv
// rtl/ram_fifo_ctrl_if.sv - push/pop streams and RAM port bundle for ram_fifo_ctrl
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16
);
    localparam int AW = $clog2(N_WORDS);
    localparam int LW = $clog2(N_WORDS + 2);

    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [LW-1:0]         level;
    logic                  ram_we;
    logic                  ram_re;
    logic [AW-1:0]         ram_address;
    logic [DATA_WIDTH-1:0] ram_data_in;
    logic [DATA_WIDTH-1:0] ram_data_out;

    modport slave (
        input  push_valid, push_data, pop_ready, ram_data_out,
        output push_ready, pop_valid, pop_data, level,
               ram_we, ram_re, ram_address, ram_data_in
    );

    modport master (
        output push_valid, push_data, pop_ready, ram_data_out,
        input  push_ready, pop_valid, pop_data, level,
               ram_we, ram_re, ram_address, ram_data_in
    );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller over a single-port RAM with a one-entry output register
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int N_WORDS    = 16
) (
    input  logic           clk,
    input  logic           rst,
    ram_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(N_WORDS);
    localparam int CW = $clog2(N_WORDS + 1);
    localparam int LW = $clog2(N_WORDS + 2);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         mem_count_q, mem_count_d;
    logic                  rd_inflight_q, rd_inflight_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic pop_fire;
    logic read_issue;
    logic push_ready;
    logic push_fire;

    always_comb begin
        pop_fire   = out_valid_q & bus.pop_ready;
        // Refill reads win over pushes so the RAM sees at most one operation per cycle.
        read_issue = !rst && (mem_count_q != '0) && !rd_inflight_q && (!out_valid_q || pop_fire);
        push_ready = !rst && (mem_count_q != CW'(N_WORDS)) && !read_issue;
        push_fire  = bus.push_valid & push_ready;
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_count_d   = mem_count_q;
        rd_inflight_d = read_issue;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;

        if (push_fire) begin
            wr_ptr_d    = wr_ptr_q + AW'(1);
            mem_count_d = mem_count_q + CW'(1);
        end else if (read_issue) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            mem_count_d = mem_count_q - CW'(1);
        end

        // ram_data_out is only meaningful the cycle after a read; ignore it otherwise.
        if (rd_inflight_q) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.ram_data_out;
        end else if (pop_fire) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_count_q   <= '0;
            rd_inflight_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_count_q   <= mem_count_d;
            rd_inflight_q <= rd_inflight_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    assign bus.push_ready  = push_ready;
    assign bus.pop_valid   = out_valid_q;
    assign bus.pop_data    = out_data_q;
    assign bus.level       = LW'(mem_count_q) + LW'(rd_inflight_q) + LW'(out_valid_q);
    assign bus.ram_we      = push_fire;
    assign bus.ram_re      = read_issue;
    assign bus.ram_address = rst ? '0 : (read_issue ? rd_ptr_q : wr_ptr_q);
    assign bus.ram_data_in = bus.push_data;
endmodule
